// File: rtl/flow_stat_engine.sv
// Per-flow packet/byte statistics engine.
// The table is cleared by a sweep after reset, then updated through a
// 2-stage read-modify-write pipeline that forwards the most recent write.
// Optional build macro: STAT_CLEAR_ON_READ_EN. When it is defined, a host read
// returns the counters and then clears that flow.
module flow_stat_engine #(
  parameter int unsigned A_WIDTH = 10,
  parameter int unsigned D_WIDTH = 32,
  parameter int unsigned P_WIDTH = 32,
  parameter int unsigned S_WIDTH = 16
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               rx_valid_i,
  input  logic [A_WIDTH-1:0] rx_flow_num_i,
  input  logic [S_WIDTH-1:0] pkt_size_i,
  input  logic               rd_req_i,
  input  logic [A_WIDTH-1:0] rd_flow_num_i,
  output logic               rd_ack_o,
  output logic               rd_valid_o,
  output logic [P_WIDTH-1:0] rd_pkt_cnt_o,
  output logic [D_WIDTH-1:0] rd_byte_cnt_o,
  output logic               init_done_o,
  output logic [15:0]        drop_cnt_o
);

  localparam int unsigned E_WIDTH = P_WIDTH + D_WIDTH;
  localparam int unsigned DEPTH   = 1 << A_WIDTH;
  localparam int unsigned PW1     = P_WIDTH + 1;
  localparam int unsigned DW1     = D_WIDTH + 1;

`ifdef STAT_CLEAR_ON_READ_EN
  localparam bit CLR_ON_READ = 1'b1;
`else
  localparam bit CLR_ON_READ = 1'b0;
`endif

  typedef enum logic {INIT, RUN} state_t;

  state_t             state, state_nxt;
  logic [A_WIDTH-1:0] ptr;

  logic [E_WIDTH-1:0] table_mem [DEPTH];
  logic [E_WIDTH-1:0] table_q;

  logic               upd_issue;
  logic [A_WIDTH-1:0] s0_addr;

  logic               s1_upd, s1_rd;
  logic [A_WIDTH-1:0] s1_addr;
  logic [S_WIDTH-1:0] s1_size;

  logic               lw_valid;
  logic [A_WIDTH-1:0] lw_addr;
  logic [E_WIDTH-1:0] lw_data;

  logic [E_WIDTH-1:0] cur;
  logic [P_WIDTH-1:0] cur_pkt, new_pkt;
  logic [D_WIDTH-1:0] cur_byte, new_byte;
  logic [PW1-1:0]     pkt_ext;
  logic [DW1-1:0]     byte_ext;

  logic               wr_en;
  logic [A_WIDTH-1:0] wr_addr;
  logic [E_WIDTH-1:0] wr_data;
  logic               s1_wr;

  // Next-state logic: leave INIT once the last address has been cleared
  always_comb begin
    state_nxt = state;
    if (state == INIT && ptr == '1) state_nxt = RUN;
  end

  // State register, sweep pointer and init flag
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= INIT;
      ptr         <= '0;
      init_done_o <= 1'b0;
    end else begin
      state       <= state_nxt;
      init_done_o <= (state_nxt == RUN);
      if (state == INIT) ptr <= ptr + 1'b1;
    end
  end

  // Updates own the single read port; host reads only get it on idle cycles
  assign upd_issue = rx_valid_i & init_done_o;
  assign rd_ack_o  = rd_req_i & ~rx_valid_i & init_done_o;
  assign s0_addr   = rx_valid_i ? rx_flow_num_i : rd_flow_num_i;

  // Count updates that arrive before the table is ready, saturating
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      drop_cnt_o <= '0;
    end else if (!init_done_o && rx_valid_i && drop_cnt_o != '1) begin
      drop_cnt_o <= drop_cnt_o + 16'd1;
    end
  end

  // S0 -> S1 pipeline registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_upd  <= 1'b0;
      s1_rd   <= 1'b0;
      s1_addr <= '0;
      s1_size <= '0;
    end else begin
      s1_upd  <= upd_issue;
      s1_rd   <= rd_ack_o;
      s1_addr <= s0_addr;
      s1_size <= pkt_size_i;
    end
  end

  // S1: forward the last write when it targets the same flow, then add
  // with carry detection so the counters clamp at all-ones instead of wrapping
  always_comb begin
    cur      = (lw_valid && lw_addr == s1_addr) ? lw_data : table_q;
    cur_pkt  = cur[E_WIDTH-1:D_WIDTH];
    cur_byte = cur[D_WIDTH-1:0];
    pkt_ext  = {1'b0, cur_pkt} + PW1'(1);
    byte_ext = {1'b0, cur_byte} + DW1'(s1_size);
    new_pkt  = pkt_ext[P_WIDTH]  ? '1 : pkt_ext[P_WIDTH-1:0];
    new_byte = byte_ext[D_WIDTH] ? '1 : byte_ext[D_WIDTH-1:0];
  end

  // Table write mux: the clear sweep during INIT, S1 write-back during RUN
  always_comb begin
    s1_wr   = s1_upd | (s1_rd & CLR_ON_READ);
    wr_en   = 1'b0;
    wr_addr = s1_addr;
    wr_data = '0;
    if (state == INIT) begin
      wr_en   = 1'b1;
      wr_addr = ptr;
    end else if (s1_wr) begin
      wr_en   = 1'b1;
      wr_data = s1_upd ? {new_pkt, new_byte} : '0;
    end
  end

  // Dual-port table storage; contents are not reset, the sweep clears them
  always_ff @(posedge clk_i) begin
    if (wr_en) table_mem[wr_addr] <= wr_data;
    table_q <= table_mem[s0_addr];
  end

  // Last-write register mirrors the most recent S1 write-back
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      lw_valid <= 1'b0;
      lw_addr  <= '0;
      lw_data  <= '0;
    end else if (state == RUN && s1_wr) begin
      lw_valid <= 1'b1;
      lw_addr  <= s1_addr;
      lw_data  <= wr_data;
    end
  end

  // Host read response; counters hold between responses
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_valid_o    <= 1'b0;
      rd_pkt_cnt_o  <= '0;
      rd_byte_cnt_o <= '0;
    end else begin
      rd_valid_o <= s1_rd;
      if (s1_rd) begin
        rd_pkt_cnt_o  <= cur_pkt;
        rd_byte_cnt_o <= cur_byte;
      end
    end
  end

endmodule

// File: tb/tb_flow_stat_engine.sv
// Scoreboard bench for flow_stat_engine, built with a 16-bit byte counter so
// that saturation can be reached quickly.
module tb_flow_stat_engine;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 16;
  localparam int unsigned PW = 32;
  localparam int unsigned SW = 16;

`ifdef STAT_CLEAR_ON_READ_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx_valid = 1'b0;
  logic [AW-1:0] rx_flow = '0;
  logic [SW-1:0] pkt_size = '0;
  logic          rd_req = 1'b0;
  logic [AW-1:0] rd_flow = '0;
  logic          rd_ack;
  logic          rd_valid;
  logic [PW-1:0] rd_pkt;
  logic [DW-1:0] rd_bytes;
  logic          init_done;
  logic [15:0]   drop_cnt;

  flow_stat_engine #(
    .A_WIDTH(AW),
    .D_WIDTH(DW),
    .P_WIDTH(PW),
    .S_WIDTH(SW)
  ) dut (
    .clk_i(clk),
    .rst_n_i(rst_n),
    .rx_valid_i(rx_valid),
    .rx_flow_num_i(rx_flow),
    .pkt_size_i(pkt_size),
    .rd_req_i(rd_req),
    .rd_flow_num_i(rd_flow),
    .rd_ack_o(rd_ack),
    .rd_valid_o(rd_valid),
    .rd_pkt_cnt_o(rd_pkt),
    .rd_byte_cnt_o(rd_bytes),
    .init_done_o(init_done),
    .drop_cnt_o(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PW-1:0] pkt;
    logic [DW-1:0] bytes;
    int unsigned   cyc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pop expected response on every rd_valid, check hold otherwise
  logic          have_last = 1'b0;
  logic [PW-1:0] last_pkt = '0;
  logic [DW-1:0] last_bytes = '0;
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (rd_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rd_valid: got pkt=%0d bytes=%0d expected no response", rd_pkt, rd_bytes);
        end else begin
          e = sb.pop_front();
          check("rd_pkt", 64'(rd_pkt), 64'(e.pkt));
          check("rd_bytes", 64'(rd_bytes), 64'(e.bytes));
          check("rd_latency_cycle", 64'(cyc), 64'(e.cyc));
          last_pkt   = rd_pkt;
          last_bytes = rd_bytes;
          have_last  = 1'b1;
        end
      end else if (have_last) begin
        check("hold_pkt", 64'(rd_pkt), 64'(last_pkt));
        check("hold_bytes", 64'(rd_bytes), 64'(last_bytes));
      end
    end
  end

  task automatic upd(input logic [AW-1:0] f, input logic [SW-1:0] s);
    rx_valid = 1'b1;
    rx_flow  = f;
    pkt_size = s;
    @(negedge clk);
  endtask

  task automatic idle();
    rx_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_read(input logic [AW-1:0] f, input logic [PW-1:0] ep, input logic [DW-1:0] eb);
    exp_t e;
    bit   acked;
    acked    = 1'b0;
    rx_valid = 1'b0;
    rd_req   = 1'b1;
    rd_flow  = f;
    for (int i = 0; i < 20 && !acked; i++) begin
      #1;
      if (rd_ack) begin
        e.pkt   = ep;
        e.bytes = eb;
        e.cyc   = cyc + 2;
        sb.push_back(e);
        acked = 1'b1;
      end
      @(negedge clk);
    end
    rd_req = 1'b0;
    if (!acked) begin
      checks++;
      errors++;
      $display("FAIL rd_ack_timeout flow %0d: got no ack in 20 cycles expected ack", f);
    end
  endtask

  initial begin
    exp_t e;
    int   edges;
    bit   seen;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_rd_valid", 64'(rd_valid), 64'(0));
    check("rst_rd_pkt", 64'(rd_pkt), 64'(0));
    check("rst_rd_bytes", 64'(rd_bytes), 64'(0));
    check("rst_init_done", 64'(init_done), 64'(0));
    check("rst_drop_cnt", 64'(drop_cnt), 64'(0));

    // Release reset with 5 updates arriving during the sweep
    rst_n    = 1'b1;
    rx_valid = 1'b1;
    rx_flow  = 10'd2;
    pkt_size = 16'd50;
    edges = 0;
    seen  = 1'b0;
    for (int k = 1; k <= 2000 && !seen; k++) begin
      @(negedge clk);
      if (init_done) begin
        seen  = 1'b1;
        edges = k;
      end
      if (k == 5) rx_valid = 1'b0;
      if (k == 10) begin
        rd_req  = 1'b1;
        rd_flow = 10'd0;
        #1 check("init_rd_ack_blocked", 64'(rd_ack), 64'(0));
      end
      if (k == 11) rd_req = 1'b0;
    end
    // init_done first seen after 1024 edges, i.e. in cycle 1025
    check("init_done_edges", 64'(edges), 64'(1024));
    check("drop_cnt", 64'(drop_cnt), 64'(5));

    do_read(10'd1023, 0, 0);

    // Single update, one idle cycle, then read
    upd(10'd7, 16'd64);
    idle();
    do_read(10'd7, 1, 64);

    // Back-to-back same-flow updates with an immediate read
    upd(10'd3, 16'd100);
    upd(10'd3, 16'd200);
    upd(10'd3, 16'd300);
    do_read(10'd3, 3, 600);

    // Alternating flows
    upd(10'd20, 16'd100);
    upd(10'd21, 16'd200);
    upd(10'd20, 16'd300);
    do_read(10'd20, 2, 400);
    do_read(10'd21, 1, 200);

    // Arbitration: read held off while updates stream in
    rd_req  = 1'b1;
    rd_flow = 10'd11;
    for (int i = 0; i < 4; i++) begin
      rx_valid = 1'b1;
      rx_flow  = 10'd11;
      pkt_size = SW'(i + 1);
      #1 check("arb_ack_blocked", 64'(rd_ack), 64'(0));
      @(negedge clk);
    end
    rx_valid = 1'b0;
    #1 check("arb_ack_first_idle", 64'(rd_ack), 64'(1));
    if (rd_ack) begin
      e.pkt   = 4;
      e.bytes = 10;
      e.cyc   = cyc + 2;
      sb.push_back(e);
    end
    @(negedge clk);
    rd_req = 1'b0;
    idle();

    // Zero-size packet counts but adds no bytes
    upd(10'd12, 16'd0);
    upd(10'd12, 16'd5);
    idle();
    do_read(10'd12, 2, 5);

    // Read followed immediately by an update to the same flow
    upd(10'd5, 16'd64);
    upd(10'd5, 16'd64);
    idle();
    do_read(10'd5, 2, 128);
    upd(10'd5, 16'd10);
    do_read(10'd5, CLR ? 1 : 3, CLR ? 10 : 138);

    // Byte counter saturation: 1100 * 60 = 66000 exceeds 16'hFFFF
    for (int i = 0; i < 1100; i++) upd(10'd9, 16'd60);
    do_read(10'd9, 1100, 16'hFFFF);

    repeat (6) idle();
    check("scoreboard_empty", 64'(sb.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
